// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - integer reservation station with operand wake-up and single-cycle ALU
// Holds issued ALU/branch-compare ops, snoops two result buses, dispatches lowest-index ready entry.
module reservation_station #(
    parameter int RS_SIZE  = 8,
    parameter int ROB_ADDR = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                issue_valid,
    input  logic [3:0]          issue_op,
    input  logic [31:0]         issue_vj,
    input  logic [31:0]         issue_vk,
    input  logic                issue_qj_busy,
    input  logic                issue_qk_busy,
    input  logic [ROB_ADDR-1:0] issue_qj,
    input  logic [ROB_ADDR-1:0] issue_qk,
    input  logic [ROB_ADDR-1:0] issue_rob,
    input  logic                cdb0_valid,
    input  logic [ROB_ADDR-1:0] cdb0_rob,
    input  logic [31:0]         cdb0_value,
    input  logic                cdb1_valid,
    input  logic [ROB_ADDR-1:0] cdb1_rob,
    input  logic [31:0]         cdb1_value,
    output logic                RS_full,
    output logic                RS_valid,
    output logic [ROB_ADDR-1:0] RS_ROBindex,
    output logic [31:0]         RS_value
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]  busy;
    logic [RS_SIZE-1:0]  qj_busy;
    logic [RS_SIZE-1:0]  qk_busy;
    logic [RS_SIZE-1:0]  ready;
    logic [3:0]          op  [RS_SIZE];
    logic [31:0]         vj  [RS_SIZE];
    logic [31:0]         vk  [RS_SIZE];
    logic [ROB_ADDR-1:0] qj  [RS_SIZE];
    logic [ROB_ADDR-1:0] qk  [RS_SIZE];
    logic [ROB_ADDR-1:0] rob [RS_SIZE];

    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_valid;
    logic [31:0]         iss_vj;
    logic [31:0]         iss_vk;
    logic                iss_qj_busy;
    logic                iss_qk_busy;
    logic [31:0]         alu_result;

    function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        lt_s;
        logic        lt_u;
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        r    = '0;
        case (f)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a >> b[4:0];
            4'd7:  r = $signed(a) >>> b[4:0];
            4'd8:  r = {31'd0, lt_s};
            4'd9:  r = {31'd0, lt_u};
            4'd10: r = {31'd0, a == b};
            4'd11: r = {31'd0, a != b};
            4'd12: r = {31'd0, lt_s};
            4'd13: r = {31'd0, ~lt_s};
            4'd14: r = {31'd0, lt_u};
            4'd15: r = {31'd0, ~lt_u};
        endcase
        return r;
    endfunction

    assign ready   = busy & ~qj_busy & ~qk_busy;
    assign RS_full = &busy;

    // Downward scan so the last hit written is the lowest index.
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
            if (ready[i]) begin
                sel_idx   = IDX_W'(i);
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        iss_vj      = issue_vj;
        iss_vk      = issue_vk;
        iss_qj_busy = issue_qj_busy;
        iss_qk_busy = issue_qk_busy;
        if (issue_qj_busy) begin
            if (cdb0_valid && cdb0_rob == issue_qj) begin
                iss_vj      = cdb0_value;
                iss_qj_busy = 1'b0;
            end else if (cdb1_valid && cdb1_rob == issue_qj) begin
                iss_vj      = cdb1_value;
                iss_qj_busy = 1'b0;
            end
        end
        if (issue_qk_busy) begin
            if (cdb0_valid && cdb0_rob == issue_qk) begin
                iss_vk      = cdb0_value;
                iss_qk_busy = 1'b0;
            end else if (cdb1_valid && cdb1_rob == issue_qk) begin
                iss_vk      = cdb1_value;
                iss_qk_busy = 1'b0;
            end
        end
    end

    assign alu_result = alu(op[sel_idx], vj[sel_idx], vk[sel_idx]);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy        <= '0;
            qj_busy     <= '0;
            qk_busy     <= '0;
            RS_valid    <= 1'b0;
            RS_ROBindex <= '0;
            RS_value    <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op[i]  <= '0;
                vj[i]  <= '0;
                vk[i]  <= '0;
                qj[i]  <= '0;
                qk[i]  <= '0;
                rob[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                busy     <= '0;
                RS_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && qj_busy[i]) begin
                        if (cdb0_valid && cdb0_rob == qj[i]) begin
                            vj[i]      <= cdb0_value;
                            qj_busy[i] <= 1'b0;
                        end else if (cdb1_valid && cdb1_rob == qj[i]) begin
                            vj[i]      <= cdb1_value;
                            qj_busy[i] <= 1'b0;
                        end
                    end
                    if (busy[i] && qk_busy[i]) begin
                        if (cdb0_valid && cdb0_rob == qk[i]) begin
                            vk[i]      <= cdb0_value;
                            qk_busy[i] <= 1'b0;
                        end else if (cdb1_valid && cdb1_rob == qk[i]) begin
                            vk[i]      <= cdb1_value;
                            qk_busy[i] <= 1'b0;
                        end
                    end
                end
                if (sel_valid) begin
                    busy[sel_idx] <= 1'b0;
                end
                // The free slot is never the dispatched one, so these writes cannot collide.
                if (issue_valid && !RS_full) begin
                    busy[free_idx]    <= 1'b1;
                    op[free_idx]      <= issue_op;
                    vj[free_idx]      <= iss_vj;
                    vk[free_idx]      <= iss_vk;
                    qj_busy[free_idx] <= iss_qj_busy;
                    qk_busy[free_idx] <= iss_qk_busy;
                    qj[free_idx]      <= issue_qj;
                    qk[free_idx]      <= issue_qk;
                    rob[free_idx]     <= issue_rob;
                end
                RS_valid <= sel_valid;
                if (sel_valid) begin
                    RS_ROBindex <= rob[sel_idx];
                    RS_value    <= alu_result;
                end
            end
        end
    end

endmodule
